// File: rtl/ste_avg_ctrl.sv
// Sequencing controller for the multimeter averaging filter: restart, settle,
// prime and run phases, plus decimation of filtered samples into display updates.
module ste_avg_ctrl #(
  parameter int DATA_W   = 16,
  parameter int SETTLE_N = 4,
  parameter int DISP_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  input  logic [2:0]        mode_i,
  input  logic              avg_req_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] avg_data_i,
  output logic [DATA_W-1:0] avg_din_o,
  output logic              avg_stb_o,
  output logic              avg_en_o,
  output logic              avg_clr_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_vld_o,
  output logic              settled_o
);

  localparam int SW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
  localparam int DW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_N);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DISP_DIV - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_SETTLE, ST_PRIME, ST_RUN} state_t;

  state_t            r_state;
  logic [2:0]        r_mode_q;
  logic              r_req_q;
  logic [SW-1:0]     r_settle_cnt;
  logic [DW-1:0]     r_dec_cnt;
  logic [DATA_W-1:0] r_avg_din;
  logic              r_avg_stb;
  logic              r_avg_en;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_vld;

  logic w_restart;
  logic w_settled;

  assign w_restart = (mode_i != r_mode_q) || (avg_req_i != r_req_q);
  assign w_settled = (r_state == ST_PRIME) || (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_mode_q     <= mode_i;
      r_req_q      <= avg_req_i;
      r_settle_cnt <= SETTLE_LD;
      r_dec_cnt    <= '0;
      r_avg_din    <= '0;
      r_avg_stb    <= 1'b0;
      r_avg_en     <= 1'b0;
      r_disp_data  <= '0;
      r_disp_vld   <= 1'b0;
    end else begin
      r_mode_q   <= mode_i;
      r_req_q    <= avg_req_i;
      r_avg_stb  <= 1'b0;
      r_disp_vld <= 1'b0;
      if (w_restart) begin
        // Abort immediately: in-flight pulses finish, nothing new is issued.
        r_state  <= ST_CLEAR;
        r_avg_en <= 1'b0;
      end else begin
        if (r_avg_stb && w_settled) begin
          if (r_dec_cnt == DIV_LAST) begin
            r_dec_cnt <= '0;
            if (!hold_i) begin
              r_disp_data <= avg_data_i;
              r_disp_vld  <= 1'b1;
            end
          end else begin
            r_dec_cnt <= r_dec_cnt + 1'b1;
          end
        end
        case (r_state)
          ST_CLEAR: begin
            r_settle_cnt <= SETTLE_LD;
            r_dec_cnt    <= '0;
            r_avg_en     <= 1'b0;
            r_state      <= (SETTLE_N == 0) ? ST_PRIME : ST_SETTLE;
          end
          ST_SETTLE: begin
            r_avg_en <= 1'b0;
            if (sample_vld_i) begin
              r_settle_cnt <= r_settle_cnt - 1'b1;
              if (r_settle_cnt == SW'(1)) r_state <= ST_PRIME;
            end
          end
          ST_PRIME: begin
            // The priming strobe goes out with averaging off so the filter loads it.
            r_avg_en <= 1'b0;
            if (sample_vld_i) begin
              r_avg_din <= sample_i;
              r_avg_stb <= 1'b1;
              r_state   <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_avg_en <= avg_req_i;
            if (sample_vld_i) begin
              r_avg_din <= sample_i;
              r_avg_stb <= 1'b1;
            end
          end
          default: r_state <= ST_CLEAR;
        endcase
      end
    end
  end

  assign avg_din_o   = r_avg_din;
  assign avg_stb_o   = r_avg_stb;
  assign avg_en_o    = r_avg_en;
  assign avg_clr_o   = (r_state == ST_CLEAR);
  assign disp_data_o = r_disp_data;
  assign disp_vld_o  = r_disp_vld;
  assign settled_o   = w_settled;

endmodule
